// File: rtl/palette_ram_if.sv
// Pixel lookup and CPU programming port bundle for palette_ram.
// master drives pixel index, blank and CPU strobes; slave returns rgb and readback data.
interface palette_ram_if #(
    parameter int COLOR_BITS = 4,
    parameter int CHAN_BITS  = 4
);
    logic [COLOR_BITS-1:0]  color;
    logic                   blank;
    logic [3*CHAN_BITS-1:0] rgb;
    logic                   cpu_ptr_we;
    logic                   cpu_data_we;
    logic [7:0]             cpu_din;
    logic [7:0]             cpu_dout;
    logic                   cpu_data_rd;

    modport master (
        output color, blank, cpu_ptr_we, cpu_data_we, cpu_din, cpu_data_rd,
        input  rgb, cpu_dout
    );

    modport slave (
        input  color, blank, cpu_ptr_we, cpu_data_we, cpu_din, cpu_data_rd,
        output rgb, cpu_dout
    );
endinterface

// File: rtl/palette_ram.sv
// CPU-programmable colour palette: registered index->RGB lookup, 1-cycle latency, no backpressure.
// Define PALETTE_READBACK_EN to build the cpu_dout readback path; otherwise cpu_dout is tied to 0.
module palette_ram #(
    parameter int COLOR_BITS = 4,
    parameter int CHAN_BITS  = 4
) (
    input  logic          clk,
    input  logic          reset,
    palette_ram_if.slave  bus
);
    localparam int ENTRIES = 1 << COLOR_BITS;
    localparam int RGB_W   = 3 * CHAN_BITS;

    localparam logic [11:0] DEFAULTS [16] = '{
        12'h000, 12'h000, 12'h2C3, 12'h5D6, 12'h54F, 12'h76F, 12'hD54, 12'h4EF,
        12'hF54, 12'hF76, 12'hDC3, 12'hED6, 12'h2B2, 12'hC5C, 12'hCCC, 12'hFFF
    };

    typedef enum logic {FIRST, SECOND} phase_t;

    logic [RGB_W-1:0]      r_pal [ENTRIES];
    logic [RGB_W-1:0]      r_rgb;
    logic [COLOR_BITS-1:0] r_ptr;
    logic [7:0]            r_lat;
    phase_t                r_phase;

    // Keep the top CHAN_BITS of each 4-bit channel of a 12-bit RGB word.
    function automatic logic [RGB_W-1:0] trunc12(input logic [11:0] w);
        return {w[11 -: CHAN_BITS], w[7 -: CHAN_BITS], w[3 -: CHAN_BITS]};
    endfunction

`ifdef PALETTE_READBACK_EN
    logic [7:0]       r_dout;
    logic [RGB_W-1:0] w_rd_ent;

    function automatic logic [3:0] nib(input logic [CHAN_BITS-1:0] c);
        logic [3:0] n;
        n = '0;
        n[3 -: CHAN_BITS] = c;
        return n;
    endfunction

    assign w_rd_ent     = r_pal[r_ptr];
    assign bus.cpu_dout = r_dout;
`else
    logic w_unused_rd;
    assign w_unused_rd  = bus.cpu_data_rd;
    assign bus.cpu_dout = 8'h00;
`endif

    assign bus.rgb = r_rgb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb   <= '0;
            r_ptr   <= '0;
            r_lat   <= '0;
            r_phase <= FIRST;
            for (int i = 0; i < ENTRIES; i++)
                r_pal[i] <= (i < 16) ? trunc12(DEFAULTS[i % 16]) : '0;
`ifdef PALETTE_READBACK_EN
            r_dout  <= '0;
`endif
        end else begin
            // Non-blocking update gives read-before-write on a same-entry commit.
            r_rgb <= bus.blank ? '0 : r_pal[bus.color];
            if (bus.cpu_ptr_we) begin
                r_ptr   <= bus.cpu_din[COLOR_BITS-1:0];
                r_phase <= FIRST;
            end else if (bus.cpu_data_we) begin
                if (r_phase == FIRST) begin
                    r_lat   <= bus.cpu_din;
                    r_phase <= SECOND;
                end else begin
                    r_pal[r_ptr] <= trunc12({r_lat[7:4], bus.cpu_din[3:0], r_lat[3:0]});
                    r_ptr        <= r_ptr + COLOR_BITS'(1);
                    r_phase      <= FIRST;
                end
            end
`ifdef PALETTE_READBACK_EN
            else if (bus.cpu_data_rd) begin
                if (r_phase == FIRST) begin
                    r_dout  <= {nib(w_rd_ent[RGB_W-1 -: CHAN_BITS]), nib(w_rd_ent[CHAN_BITS-1:0])};
                    r_phase <= SECOND;
                end else begin
                    r_dout  <= {4'h0, nib(w_rd_ent[2*CHAN_BITS-1 -: CHAN_BITS])};
                    r_ptr   <= r_ptr + COLOR_BITS'(1);
                    r_phase <= FIRST;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_palette_ram.sv
// Scoreboard bench for palette_ram: stimulus pushes model expectations, monitor pops and compares.
module tb_palette_ram;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    palette_ram_if #(.COLOR_BITS(4), .CHAN_BITS(4)) bus ();
    palette_ram_if #(.COLOR_BITS(8), .CHAN_BITS(2)) bus2 ();

    palette_ram #(.COLOR_BITS(4), .CHAN_BITS(4)) u_dut (.clk(clk), .reset(reset), .bus(bus));
    palette_ram #(.COLOR_BITS(8), .CHAN_BITS(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    localparam logic [11:0] DEF [16] = '{
        12'h000, 12'h000, 12'h2C3, 12'h5D6, 12'h54F, 12'h76F, 12'hD54, 12'h4EF,
        12'hF54, 12'hF76, 12'hDC3, 12'hED6, 12'h2B2, 12'hC5C, 12'hCCC, 12'hFFF
    };

    typedef struct {
        int unsigned which;
        logic [11:0] rgb;
        logic [7:0]  dout;
        bit          chk_dout;
        string       name;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: palette contents as 12-bit words, pointer, phase, latched byte.
    logic [11:0] m_pal [16];
    int          m_ptr;
    bit          m_second;
    logic [7:0]  m_lat;
    logic [7:0]  m_dout;

    function automatic void model_init();
        for (int i = 0; i < 16; i++) m_pal[i] = DEF[i];
        m_ptr = 0; m_second = 0; m_lat = 8'h00; m_dout = 8'h00;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.which == 0) begin
                    check({e.name, " rgb"}, bus.rgb, e.rgb);
                    if (e.chk_dout) check({e.name, " dout"}, {4'h0, bus.cpu_dout}, {4'h0, e.dout});
                end else begin
                    check({e.name, " rgb2"}, {6'h0, bus2.rgb}, e.rgb);
                    if (e.chk_dout) check({e.name, " dout2"}, {4'h0, bus2.cpu_dout}, {4'h0, e.dout});
                end
            end
        end
    end

    task automatic step(input logic [3:0] color, input logic blank, input logic pw, input logic dw,
                        input logic rd, input logic [7:0] din, input string name);
        exp_t e;
        logic [11:0] ent;
        @(negedge clk);
        bus.color = color; bus.blank = blank; bus.cpu_ptr_we = pw;
        bus.cpu_data_we = dw; bus.cpu_data_rd = rd; bus.cpu_din = din;
        bus2.cpu_ptr_we = 1'b0; bus2.cpu_data_we = 1'b0; bus2.cpu_data_rd = 1'b0;
        e.which = 0; e.name = name; e.chk_dout = 1'b1;
        e.rgb = blank ? 12'h000 : m_pal[color];
        if (pw) begin
            m_ptr = din % 16; m_second = 0;
        end else if (dw) begin
            if (!m_second) begin
                m_lat = din; m_second = 1;
            end else begin
                m_pal[m_ptr] = {m_lat[7:4], din[3:0], m_lat[3:0]};
                m_ptr = (m_ptr + 1) % 16; m_second = 0;
            end
        end
`ifdef PALETTE_READBACK_EN
        else if (rd) begin
            ent = m_pal[m_ptr];
            if (!m_second) begin
                m_dout = {ent[11:8], ent[3:0]}; m_second = 1;
            end else begin
                m_dout = {4'h0, ent[7:4]};
                m_ptr = (m_ptr + 1) % 16; m_second = 0;
            end
        end
`else
        ent = 12'h000;
`endif
        e.dout = m_dout;
        q.push_back(e);
    endtask

    task automatic step2(input logic [7:0] color, input logic pw, input logic rd, input logic [7:0] din,
                         input logic [5:0] exp_rgb, input logic [7:0] exp_dout, input string name);
        exp_t e;
        @(negedge clk);
        bus2.color = color; bus2.blank = 1'b0; bus2.cpu_ptr_we = pw;
        bus2.cpu_data_we = 1'b0; bus2.cpu_data_rd = rd; bus2.cpu_din = din;
        bus.cpu_ptr_we = 1'b0; bus.cpu_data_we = 1'b0; bus.cpu_data_rd = 1'b0;
        e.which = 1; e.name = name; e.rgb = {6'h0, exp_rgb}; e.dout = exp_dout; e.chk_dout = 1'b1;
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        bus.cpu_ptr_we = 1'b0; bus.cpu_data_we = 1'b0; bus.cpu_data_rd = 1'b0;
        reset = 1'b1;
        model_init();
        @(negedge clk);
        check("reset rgb", bus.rgb, 12'h000);
        check("reset dout", {4'h0, bus.cpu_dout}, 12'h000);
        check("reset rgb2", {6'h0, bus2.rgb}, 12'h000);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : stim
        bus.color = '0; bus.blank = 1'b0; bus.cpu_ptr_we = 1'b0; bus.cpu_data_we = 1'b0;
        bus.cpu_din = '0; bus.cpu_data_rd = 1'b0;
        bus2.color = '0; bus2.blank = 1'b0; bus2.cpu_ptr_we = 1'b0; bus2.cpu_data_we = 1'b0;
        bus2.cpu_din = '0; bus2.cpu_data_rd = 1'b0;
        model_init();
        do_reset();

        for (int i = 0; i < 16; i++) step(4'(i), 0, 0, 0, 0, 8'h00, "default lookup");
        step(4'd15, 1, 0, 0, 0, 8'h00, "blank");

        step(4'd0, 0, 1, 0, 0, 8'h03, "ptr 3");
        step(4'd0, 0, 0, 1, 0, 8'hA5, "wr A5");
        step(4'd0, 0, 0, 1, 0, 8'h07, "wr 07");
        step(4'd3, 0, 0, 0, 0, 8'h00, "entry 3");
        step(4'd0, 0, 0, 1, 0, 8'h11, "wr 11");
        step(4'd4, 0, 0, 1, 0, 8'h22, "collide 4");
        step(4'd4, 0, 0, 0, 0, 8'h00, "entry 4");

        step(4'd0, 0, 1, 0, 0, 8'h07, "ptr 7");
        step(4'd0, 0, 0, 1, 0, 8'h9C, "wr 9C");
        step(4'd7, 0, 0, 1, 0, 8'h0D, "collide 7");
        step(4'd7, 0, 0, 0, 0, 8'h00, "entry 7");

        step(4'd0, 0, 1, 0, 0, 8'hFF, "ptr 15 upper bits");
        step(4'd0, 0, 0, 1, 0, 8'h11, "wrap 11");
        step(4'd0, 0, 0, 1, 0, 8'h02, "wrap 02");
        step(4'd0, 0, 0, 1, 0, 8'h33, "wrap 33");
        step(4'd0, 0, 0, 1, 0, 8'h04, "wrap 04");
        step(4'd15, 0, 0, 0, 0, 8'h00, "entry 15");
        step(4'd0, 0, 0, 0, 0, 8'h00, "entry 0 wrap");

        step(4'd0, 0, 0, 1, 0, 8'hF0, "wr F0");
        step(4'd0, 0, 1, 1, 0, 8'h05, "ptr beats data");
        step(4'd0, 0, 0, 1, 0, 8'h12, "wr 12");
        step(4'd0, 0, 0, 1, 0, 8'h03, "wr 03");
        for (int i = 0; i < 16; i++) step(4'(i), 0, 0, 0, 0, 8'h00, "sweep");

        step(4'd0, 0, 0, 1, 0, 8'h9A, "pre-reset first byte");
        do_reset();
        step(4'd0, 0, 0, 1, 0, 8'h56, "post-reset 56");
        step(4'd0, 0, 0, 1, 0, 8'h78, "post-reset 78");
        step(4'd0, 0, 0, 0, 0, 8'h00, "entry 0 post-reset");
        step(4'd1, 0, 0, 0, 0, 8'h00, "entry 1 post-reset");

`ifdef PALETTE_READBACK_EN
        step(4'd0, 0, 1, 0, 0, 8'h02, "rb ptr 2");
        step(4'd0, 0, 0, 0, 1, 8'h00, "rb RB");
        step(4'd0, 0, 0, 0, 1, 8'h00, "rb G");
        step(4'd0, 0, 0, 1, 1, 8'hE1, "wr beats rd");
`endif

        for (int n = 0; n < 1500; n++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) < 3),
                 ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), "random");
        end
        for (int i = 0; i < 16; i++) step(4'(i), 0, 0, 0, 0, 8'h00, "final sweep");

        step2(8'd2, 0, 0, 8'h00, 6'b001100, 8'h00, "narrow entry 2");
        step2(8'd200, 0, 0, 8'h00, 6'b000000, 8'h00, "narrow entry 200");
        step2(8'd15, 0, 0, 8'h00, 6'b111111, 8'h00, "narrow entry 15");
`ifdef PALETTE_READBACK_EN
        step2(8'd0, 1, 0, 8'h02, 6'b000000, 8'h00, "narrow ptr 2");
        step2(8'd0, 0, 1, 8'h00, 6'b000000, 8'h00, "narrow rd RB");
        step2(8'd0, 0, 1, 8'h00, 6'b000000, 8'h0C, "narrow rd G");
`endif

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
